// File: rtl/mfp_ahb_interconnect_if.sv
// AHB-lite bundle between the MIPSfpga core bus, the interconnect and its
// N_SLV memory-mapped slaves.
// The slave modport is the interconnect's own view of the bus.
// The master modport belongs to whatever drives the core bus and hosts the
// slave models.
interface mfp_ahb_interconnect_if #(
   parameter int N_SLV = 6,
   parameter int CNT_W = 16
);
   // master address phase
   logic [31:0]         HADDR;
   logic [1:0]          HTRANS;
   logic                HWRITE;
   // response back to the master
   logic [31:0]         HRDATA;
   logic                HREADY;
   logic                HRESP;
   // per-slave selects and responses
   logic [N_SLV-1:0]    HSEL_S;
   logic [32*N_SLV-1:0] HRDATA_S;
   logic [N_SLV-1:0]    HREADYOUT_S;
   logic [N_SLV-1:0]    HRESP_S;
   // error reporting
   logic                ERR_UNMAPPED;
   logic                ERR_TIMEOUT;
   logic [CNT_W-1:0]    ERR_CNT;

   modport slave (
      input  HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
      output HRDATA, HREADY, HRESP, HSEL_S, ERR_UNMAPPED, ERR_TIMEOUT, ERR_CNT
   );

   modport master (
      output HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
      input  HRDATA, HREADY, HRESP, HSEL_S, ERR_UNMAPPED, ERR_TIMEOUT, ERR_CNT
   );
endinterface

// File: rtl/mfp_ahb_interconnect.sv
// Parametrised AHB-lite interconnect for the MIPSfpga core bus.
// The address phase is decoded combinationally onto N_SLV base/mask windows
// (lowest index wins on overlap). The selected slave's data-phase response is
// muxed back through a registered select.
// Unmapped NONSEQ/SEQ transfers are answered by a built-in default slave with
// a two-cycle ERROR. A watchdog aborts a slave that holds HREADYOUT low for too
// long, also with a two-cycle ERROR. Every ERROR completion is counted in a
// saturating counter.
module mfp_ahb_interconnect #(
   parameter int                  N_SLV       = 6,
   parameter logic [32*N_SLV-1:0] SLV_BASE    = {N_SLV{32'h0}},
   parameter logic [32*N_SLV-1:0] SLV_MASK    = {N_SLV{32'h0}},
   parameter int                  TIMEOUT_CYC = 255,
   parameter int                  CNT_W       = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   mfp_ahb_interconnect_if.slave ahb
);

   localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   // Holds 0..TIMEOUT_CYC with headroom, even when the watchdog is disabled.
   localparam int WC_W  = $clog2(TIMEOUT_CYC + 2);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SLV  = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nx;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nx;
   logic             r_cause_to;   // 1 = ERROR came from the watchdog, 0 = unmapped
   logic             w_cause_nx;
   logic [WC_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   logic             w_hit;
   logic [SEL_W-1:0] w_hit_idx;
   logic [N_SLV-1:0] w_hsel;

   logic             w_s_rdy;
   logic             w_s_resp;
   logic [31:0]      w_s_data;

   logic             w_hready;
   logic             w_hresp;
   logic [31:0]      w_hrdata;
   logic             w_timeout;
   logic             w_err_evt;
   logic             w_unused;

   // HWRITE only matters to the slaves, and NONSEQ/SEQ are decoded identically.
   assign w_unused = ^{ahb.HWRITE, ahb.HTRANS[0]};

   // Address decode: scan from the top so the lowest-index hit overwrites the rest.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_hsel    = '0;
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if ((ahb.HADDR & SLV_MASK[32*k +: 32]) == (SLV_BASE[32*k +: 32] & SLV_MASK[32*k +: 32])) begin
            w_hit     = 1'b1;
            w_hit_idx = SEL_W'(k);
         end
      end
      for (int k = 0; k < N_SLV; k++) begin
         w_hsel[k] = w_hit && (w_hit_idx == SEL_W'(k));
      end
   end

   // Data-phase mux of the slave captured in the previous address phase.
   always_comb begin
      w_s_rdy  = 1'b1;
      w_s_resp = 1'b0;
      w_s_data = 32'h0;
      for (int k = 0; k < N_SLV; k++) begin
         if (r_sel == SEL_W'(k)) begin
            w_s_rdy  = ahb.HREADYOUT_S[k];
            w_s_resp = ahb.HRESP_S[k];
            w_s_data = ahb.HRDATA_S[32*k +: 32];
         end
      end
   end

   // Response seen by the master. The default slave answers outside SLV.
   always_comb begin
      w_hready = 1'b1;
      w_hresp  = 1'b0;
      w_hrdata = 32'h0;
      case (r_state)
         S_SLV: begin
            w_hready = w_s_rdy;
            w_hresp  = w_s_resp;
            w_hrdata = w_s_data;
         end
         S_ERR1: begin
            w_hready = 1'b0;
            w_hresp  = 1'b1;
         end
         S_ERR2: begin
            w_hready = 1'b1;
            w_hresp  = 1'b1;
         end
         default: ;
      endcase
   end

   // Watchdog fires while the slave is still stalling and the wait budget is spent.
   assign w_timeout = (TIMEOUT_CYC != 0) && (r_state == S_SLV) && !w_s_rdy &&
                      (r_wait_cnt == WC_W'(TIMEOUT_CYC));

   // Next state and captured select. Capture happens only on a completed cycle.
   always_comb begin
      w_state_nx = r_state;
      w_sel_nx   = r_sel;
      w_cause_nx = r_cause_to;
      if (r_state == S_ERR1) begin
         w_state_nx = S_ERR2;
      end else if (w_timeout) begin
         w_state_nx = S_ERR1;
         w_cause_nx = 1'b1;
      end else if (w_hready) begin
         if (ahb.HTRANS[1]) begin
            if (w_hit) begin
               w_state_nx = S_SLV;
               w_sel_nx   = w_hit_idx;
            end else begin
               w_state_nx = S_ERR1;
               w_cause_nx = 1'b0;
            end
         end else begin
            w_state_nx = S_IDLE;
         end
      end
   end

   // State, select and error-cause registers.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_cause_to <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_sel      <= w_sel_nx;
         r_cause_to <= w_cause_nx;
      end
   end

   // Consecutive slave wait cycles. Any completed cycle restarts the count.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_wait_cnt <= '0;
      end else if (w_hready) begin
         r_wait_cnt <= '0;
      end else if ((r_state == S_SLV) && !w_s_rdy && !w_timeout) begin
         r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end
   end

   // An ERROR completion is either the default slave's second cycle or a
   // slave-sourced ERROR finishing in SLV.
   assign w_err_evt = (r_state == S_ERR2) ||
                      ((r_state == S_SLV) && w_s_rdy && w_s_resp);

   // Saturating ERROR counter. It sticks at all-ones rather than wrapping.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_err_cnt <= '0;
      end else if (w_err_evt && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign ahb.HSEL_S       = w_hsel;
   assign ahb.HREADY       = w_hready;
   assign ahb.HRESP        = w_hresp;
   assign ahb.HRDATA       = w_hrdata;
   assign ahb.ERR_UNMAPPED = (r_state == S_ERR2) && !r_cause_to;
   assign ahb.ERR_TIMEOUT  = (r_state == S_ERR2) &&  r_cause_to;
   assign ahb.ERR_CNT      = r_err_cnt;

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Self-checking bench for mfp_ahb_interconnect.
// Transfers are described as whole transactions: address, HTRANS, slave wait
// count, slave ERROR, and stall-forever. The expected bus response for each
// data-phase cycle is derived from the transaction alone, and the bench
// follows the master's pipelining rule: the next address is held until HREADY.
module tb_mfp_ahb_interconnect;

   localparam int N    = 3;
   localparam int TO   = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;
   // slave0: 0x0xxxxxxx; slave1: 0x3xxxxxxx; slave2: any address with bit 29
   // set (overlaps slave1, which must win)
   localparam logic [32*N-1:0] BASE = {32'h2000_0000, 32'h3000_0000, 32'h0000_0000};
   localparam logic [32*N-1:0] MASK = {32'h2000_0000, 32'hF000_0000, 32'hF000_0000};

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      int          kind;   // 0 okay/no-data (IDLE, BUSY), 1 mapped slave, 2 unmapped
      int          slv;
      int          w;      // wait cycles before the slave's response
      bit          err;    // slave answers with its own two-cycle ERROR
      bit          to;     // slave never becomes ready
      logic [31:0] data;
   } xfer_t;

   logic HCLK;
   logic HRESET;
   int   n_chk;
   int   n_fail;
   int   m_cnt;

   mfp_ahb_interconnect_if #(.N_SLV(N), .CNT_W(CW)) bus ();

   mfp_ahb_interconnect #(
      .N_SLV(N), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(TO), .CNT_W(CW)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .ahb(bus)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic int ref_decode(input logic [31:0] a);
      for (int k = 0; k < N; k++)
         if ((a & MASK[32*k +: 32]) == (BASE[32*k +: 32] & MASK[32*k +: 32])) return k;
      return -1;
   endfunction

   function automatic xfer_t make_xfer(input logic [31:0] a, input logic [1:0] t, input int w,
                                       input bit err, input bit to, input logic [31:0] d);
      xfer_t x;
      int    s;
      s = ref_decode(a);
      x.addr = a; x.trans = t; x.w = w; x.err = err; x.to = to; x.data = d;
      x.slv  = (s < 0) ? 0 : s;
      if (!t[1])      x.kind = 0;
      else if (s < 0) x.kind = 2;
      else            x.kind = 1;
      return x;
   endfunction

   // What the selected slave drives in data-phase cycle j.
   function automatic void slv_cyc(input xfer_t x, input int j, output bit rdy, output bit rsp);
      if (x.to) begin
         rdy = 1'b0; rsp = 1'b0;
      end else begin
         rdy = (j >= x.w + (x.err ? 1 : 0));
         rsp = x.err && (j >= x.w);
      end
   endfunction

   // What the master must see in data-phase cycle j of transfer x.
   function automatic void exp_cyc(input xfer_t x, input int j, output bit rdy, output bit rsp,
                                   output bit last, output bit pu, output bit pt, output bit ec);
      rdy = 1'b1; rsp = 1'b0; last = 1'b0; pu = 1'b0; pt = 1'b0; ec = 1'b0;
      case (x.kind)
         0: last = 1'b1;
         2: begin
            rsp = 1'b1; rdy = (j == 1); last = rdy; pu = rdy; ec = rdy;
         end
         default: begin
            if (x.to) begin
               // TO+1 stalled cycles, then the two-cycle ERROR
               rdy = (j == TO + 2); rsp = (j > TO); last = rdy; pt = rdy; ec = rdy;
            end else begin
               slv_cyc(x, j, rdy, rsp);
               last = rdy; ec = rdy && x.err;
            end
         end
      endcase
   endfunction

   task automatic do_reset();
      HRESET = 1'b1;
      bus.HTRANS = 2'b00;
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      m_cnt  = 0;
   endtask

   // Drives a pipelined sequence of transfers and checks every cycle.
   task automatic run_stream(input xfer_t xs[$], output int ncyc);
      xfer_t       ad, dp, fill;
      int          j, ai, done, e;
      bit          rdy, rsp, last, pu, pt, ec, srdy, srsp;
      logic [N-1:0] ehsel;
      logic [31:0] ed;
      fill = make_xfer(32'h0, 2'b00, 0, 0, 0, 32'h0);
      dp = fill; j = 0; ai = 0; done = 0; ncyc = 0;
      if (xs.size() > 0) ad = xs[0]; else ad = fill;
      while (done < xs.size() + 1) begin
         bus.HADDR  = ad.addr;
         bus.HTRANS = ad.trans;
         bus.HWRITE = 1'($urandom);
         for (int k = 0; k < N; k++) begin
            bus.HREADYOUT_S[k]       = 1'($urandom);
            bus.HRESP_S[k]           = 1'($urandom);
            bus.HRDATA_S[32*k +: 32] = $urandom;
         end
         if (dp.kind == 1) begin
            slv_cyc(dp, j, srdy, srsp);
            bus.HREADYOUT_S[dp.slv]       = srdy;
            bus.HRESP_S[dp.slv]           = srsp;
            bus.HRDATA_S[32*dp.slv +: 32] = dp.data;
         end
         exp_cyc(dp, j, rdy, rsp, last, pu, pt, ec);
         @(negedge HCLK);
         e = ref_decode(bus.HADDR);
         ehsel = '0;
         if (e >= 0) ehsel[e] = 1'b1;
         n_chk++;
         if (bus.HSEL_S !== ehsel) begin
            n_fail++; $display("FAIL hsel addr=%h: got %b want %b", bus.HADDR, bus.HSEL_S, ehsel);
         end
         n_chk++;
         if (bus.HREADY !== rdy) begin
            n_fail++; $display("FAIL hready cyc%0d kind%0d: got %b want %b", j, dp.kind, bus.HREADY, rdy);
         end
         n_chk++;
         if (bus.HRESP !== rsp) begin
            n_fail++; $display("FAIL hresp cyc%0d kind%0d: got %b want %b", j, dp.kind, bus.HRESP, rsp);
         end
         n_chk++;
         if (bus.ERR_UNMAPPED !== pu) begin
            n_fail++; $display("FAIL err_unmapped cyc%0d: got %b want %b", j, bus.ERR_UNMAPPED, pu);
         end
         n_chk++;
         if (bus.ERR_TIMEOUT !== pt) begin
            n_fail++; $display("FAIL err_timeout cyc%0d: got %b want %b", j, bus.ERR_TIMEOUT, pt);
         end
         n_chk++;
         if (bus.ERR_CNT !== CW'(m_cnt)) begin
            n_fail++; $display("FAIL err_cnt: got %0d want %0d", bus.ERR_CNT, m_cnt);
         end
         if (last && !rsp && dp.kind != 2) begin
            ed = (dp.kind == 1) ? dp.data : 32'h0;
            n_chk++;
            if (bus.HRDATA !== ed) begin
               n_fail++; $display("FAIL hrdata kind%0d: got %h want %h", dp.kind, bus.HRDATA, ed);
            end
         end
         if (last && ec) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
         @(posedge HCLK); #1;
         ncyc++;
         if (last) begin
            dp = ad; j = 0; done++; ai++;
            if (ai < xs.size()) ad = xs[ai]; else ad = fill;
         end else begin
            j++;
         end
      end
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      bus.HADDR = 32'h2000_0000; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
      bus.HREADYOUT_S = '1; bus.HRESP_S = '0; bus.HRDATA_S = '0;
      @(negedge HCLK);
      n_chk++;
      if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
         n_fail++; $display("FAIL reset_resp: got %b/%b/%h want 1/0/0", bus.HREADY, bus.HRESP, bus.HRDATA);
      end
      n_chk++;
      if (bus.ERR_UNMAPPED !== 1'b0 || bus.ERR_TIMEOUT !== 1'b0 || bus.ERR_CNT !== 2'd0) begin
         n_fail++; $display("FAIL reset_err: got %b/%b/%0d want 0/0/0", bus.ERR_UNMAPPED, bus.ERR_TIMEOUT, bus.ERR_CNT);
      end
      n_chk++;
      if (bus.HSEL_S !== 3'b100) begin
         n_fail++; $display("FAIL reset_hsel: got %b want 100", bus.HSEL_S);
      end
      @(posedge HCLK); #1;
      HRESET = 1'b0; bus.HTRANS = 2'b00; m_cnt = 0;
   endtask

   task automatic test_mapped_read();
      xfer_t xs[$];
      int    nc;
      do_reset();
      xs.push_back(make_xfer(32'h2000_0000, 2'b10, 0, 0, 0, 32'hCAFE0002));
      run_stream(xs, nc);
      n_chk++;
      if (nc !== 2) begin
         n_fail++; $display("FAIL mapped_read_cycles: got %0d want 2", nc);
      end
   endtask

   task automatic test_wait_states();
      xfer_t xs[$];
      int    nc;
      do_reset();
      xs.push_back(make_xfer(32'h3000_0000, 2'b10, 3, 0, 0, 32'h1111_0001));
      xs.push_back(make_xfer(32'h2000_0004, 2'b11, 0, 0, 0, 32'h2222_0002));
      run_stream(xs, nc);
      // initial idle + 3 waits + ready + second transfer
      n_chk++;
      if (nc !== 6) begin
         n_fail++; $display("FAIL wait_cycles: got %0d want 6", nc);
      end
      n_chk++;
      if (bus.ERR_CNT !== 2'd0) begin
         n_fail++; $display("FAIL wait_errcnt: got %0d want 0", bus.ERR_CNT);
      end
      // exactly TIMEOUT_CYC waits must still complete normally
      xs.delete();
      xs.push_back(make_xfer(32'h3000_0040, 2'b10, TO, 0, 0, 32'h3333_0003));
      run_stream(xs, nc);
      n_chk++;
      if (nc !== TO + 2) begin
         n_fail++; $display("FAIL wait_boundary_cycles: got %0d want %0d", nc, TO + 2);
      end
   endtask

   task automatic test_slave_error();
      xfer_t xs[$];
      int    nc;
      do_reset();
      xs.push_back(make_xfer(32'h0000_0010, 2'b10, 1, 1, 0, 32'h0));
      xs.push_back(make_xfer(32'h7000_0000, 2'b10, 0, 0, 0, 32'h4444_0004));
      run_stream(xs, nc);
      n_chk++;
      if (bus.ERR_CNT !== 2'd1) begin
         n_fail++; $display("FAIL slave_err_cnt: got %0d want 1", bus.ERR_CNT);
      end
   endtask

   task automatic test_unmapped();
      xfer_t xs[$];
      int    nc;
      do_reset();
      xs.push_back(make_xfer(32'h1234_5678, 2'b10, 0, 0, 0, 32'h0));
      xs.push_back(make_xfer(32'h1234_5678, 2'b00, 0, 0, 0, 32'h0));
      run_stream(xs, nc);
      n_chk++;
      if (bus.ERR_CNT !== 2'd1) begin
         n_fail++; $display("FAIL unmapped_cnt: got %0d want 1", bus.ERR_CNT);
      end
      n_chk++;
      if (nc !== 4) begin
         n_fail++; $display("FAIL unmapped_cycles: got %0d want 4", nc);
      end
   endtask

   task automatic test_watchdog();
      xfer_t xs[$];
      int    nc;
      do_reset();
      xs.push_back(make_xfer(32'h3000_0010, 2'b10, 0, 0, 1, 32'h0));
      xs.push_back(make_xfer(32'h0000_0100, 2'b10, 1, 0, 0, 32'h5555_0005));
      run_stream(xs, nc);
      // initial idle + (TO+1 waits, ERR1, ERR2) + slave0 with one wait
      n_chk++;
      if (nc !== 1 + TO + 3 + 2) begin
         n_fail++; $display("FAIL watchdog_cycles: got %0d want %0d", nc, 1 + TO + 3 + 2);
      end
      n_chk++;
      if (bus.ERR_CNT !== 2'd1) begin
         n_fail++; $display("FAIL watchdog_cnt: got %0d want 1", bus.ERR_CNT);
      end
   endtask

   task automatic test_reset_in_err1();
      do_reset();
      bus.HADDR = 32'h1234_5678; bus.HTRANS = 2'b10;
      @(posedge HCLK); #1;
      n_chk++;
      if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin
         n_fail++; $display("FAIL err1_entry: got %b/%b want 0/1", bus.HREADY, bus.HRESP);
      end
      HRESET = 1'b1; bus.HADDR = 32'h0000_0004; #1;
      n_chk++;
      if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
         n_fail++; $display("FAIL rst_err1_resp: got %b/%b/%h want 1/0/0", bus.HREADY, bus.HRESP, bus.HRDATA);
      end
      n_chk++;
      if (bus.HSEL_S !== 3'b001) begin
         n_fail++; $display("FAIL rst_err1_hsel: got %b want 001", bus.HSEL_S);
      end
      @(negedge HCLK);
      n_chk++;
      if (bus.ERR_UNMAPPED !== 1'b0 || bus.ERR_TIMEOUT !== 1'b0) begin
         n_fail++; $display("FAIL rst_err1_pulse: got %b/%b want 0/0", bus.ERR_UNMAPPED, bus.ERR_TIMEOUT);
      end
      @(posedge HCLK); #1;
      n_chk++;
      if (bus.ERR_CNT !== 2'd0) begin
         n_fail++; $display("FAIL rst_err1_cnt: got %0d want 0", bus.ERR_CNT);
      end
      HRESET = 1'b0; bus.HTRANS = 2'b00; m_cnt = 0;
   endtask

   task automatic test_saturation();
      xfer_t xs[$];
      int    nc;
      do_reset();
      xs.push_back(make_xfer(32'h1234_5678, 2'b10, 0, 0, 0, 32'h0));
      xs.push_back(make_xfer(32'h4000_0000, 2'b11, 0, 0, 0, 32'h0));
      xs.push_back(make_xfer(32'h5abc_0000, 2'b10, 0, 0, 0, 32'h0));
      xs.push_back(make_xfer(32'h1000_0000, 2'b11, 0, 0, 0, 32'h0));
      xs.push_back(make_xfer(32'h8000_0000, 2'b10, 0, 0, 0, 32'h0));
      run_stream(xs, nc);
      n_chk++;
      if (bus.ERR_CNT !== 2'd3) begin
         n_fail++; $display("FAIL saturation: got %0d want 3", bus.ERR_CNT);
      end
   endtask

   task automatic test_random();
      xfer_t       xs[$];
      int          nc, w;
      bit          er, to;
      logic [31:0] a;
      for (int r = 0; r < 4; r++) begin
         do_reset();
         xs.delete();
         for (int i = 0; i < 20; i++) begin
            a  = $urandom;
            er = ($urandom_range(0, 3) == 0);
            to = ($urandom_range(0, 9) == 0);
            w  = er ? $urandom_range(0, TO - 1) : $urandom_range(0, TO);
            xs.push_back(make_xfer(a, 2'($urandom), w, er, to, $urandom));
         end
         run_stream(xs, nc);
         n_chk++;
         if (bus.ERR_CNT !== CW'(m_cnt)) begin
            n_fail++; $display("FAIL random_cnt round%0d: got %0d want %0d", r, bus.ERR_CNT, m_cnt);
         end
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; m_cnt = 0;
      test_reset();
      test_mapped_read();
      test_wait_states();
      test_slave_error();
      test_unmapped();
      test_watchdog();
      test_reset_in_err1();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
